// File: rtl/div_result_reconstructor_if.sv
// Handshake bundle for div_result_reconstructor: request triple in, reconstructed dividend out.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Optional error-statistics signals exist only when DIV_RECON_ERROR_DIST_EN is defined.
interface div_result_reconstructor_if #(
    parameter int QW = 8,
    parameter int NW = 16
`ifdef DIV_RECON_ERROR_DIST_EN
    ,
    parameter int SUMW = 32
`endif
);
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] q;
    logic [QW-1:0] d;
    logic [QW-1:0] r;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] n_rec;
`ifdef DIV_RECON_ERROR_DIST_EN
    logic [NW-1:0]   n_ref;
    logic            clear_stats;
    logic [NW-1:0]   err_abs;
    logic [SUMW-1:0] err_sum;
    logic [15:0]     txn_cnt;
`endif

    // Producer of triples and consumer of results.
    modport master (
        output in_valid, q, d, r, out_ready,
`ifdef DIV_RECON_ERROR_DIST_EN
        output n_ref, clear_stats,
        input  err_abs, err_sum, txn_cnt,
`endif
        input  in_ready, out_valid, n_rec
    );

    // The reconstructor itself.
    modport slave (
        input  in_valid, q, d, r, out_ready,
`ifdef DIV_RECON_ERROR_DIST_EN
        input  n_ref, clear_stats,
        output err_abs, err_sum, txn_cnt,
`endif
        output in_ready, out_valid, n_rec
    );
endinterface

// File: rtl/div_result_reconstructor.sv
// Rebuilds a dividend n_rec = q*d + r with a sequential shift-add multiplier.
// Latency: out_valid rises QW clocks after the accept edge; one triple per QW+2 cycles at best.
// Backpressure: result held in DONE until out_ready; no new triple is accepted until then.
// Optional dividend-error statistics are enabled by defining DIV_RECON_ERROR_DIST_EN.
module div_result_reconstructor #(
    parameter int QW = 8,
    parameter int NW = 16
`ifdef DIV_RECON_ERROR_DIST_EN
    ,
    parameter int SUMW = 32
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    div_result_reconstructor_if.slave bus
);
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [NW-1:0] acc_q;
    logic [NW-1:0] mcand_q;
    logic [QW-1:0] mplier_q;
    logic [CW-1:0] count_q;
    logic [NW-1:0] n_rec_q;
    logic [NW-1:0] acc_sum;
    logic          accept;
    logic          out_hs;
    logic          last_mul;

    assign accept   = (state_q == ST_IDLE) && bus.in_valid;
    assign out_hs   = (state_q == ST_DONE) && bus.out_ready;
    assign last_mul = (state_q == ST_MUL) && (count_q == CW'(QW - 1));
    // Partial product add for the current multiplier bit; the product never exceeds NW bits.
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.n_rec     = n_rec_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: always run all QW multiplier steps, no early exit on a zero multiplier.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_MUL;
            ST_MUL:  if (last_mul) state_d = ST_DONE;
            ST_DONE: if (out_hs)   state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Shift-add datapath; n_rec is captured separately so it survives the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            n_rec_q  <= '0;
        end else begin
            if (accept) begin
                acc_q    <= {{(NW-QW){1'b0}}, bus.r};
                mcand_q  <= {{(NW-QW){1'b0}}, bus.d};
                mplier_q <= bus.q;
                count_q  <= '0;
            end else if (state_q == ST_MUL) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + 1'b1;
                if (last_mul) begin
                    n_rec_q <= acc_sum;
                end
            end
        end
    end

`ifdef DIV_RECON_ERROR_DIST_EN
    logic [NW-1:0]   n_ref_q;
    logic [NW-1:0]   err_abs_c;
    logic [SUMW-1:0] err_sum_q;
    logic [15:0]     txn_cnt_q;
    logic [SUMW:0]   sum_ext;

    // Reference dividend captured with the triple so the source need not hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_ref_q <= '0;
        end else if (accept) begin
            n_ref_q <= bus.n_ref;
        end
    end

    // Absolute dividend error, only meaningful while the result is presented.
    always_comb begin
        err_abs_c = '0;
        if (state_q == ST_DONE) begin
            err_abs_c = (n_ref_q >= n_rec_q) ? (n_ref_q - n_rec_q) : (n_rec_q - n_ref_q);
        end
    end

    assign sum_ext = {1'b0, err_sum_q} + {{(SUMW+1-NW){1'b0}}, err_abs_c};

    // Saturating statistics; clear beats a coincident handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum_q <= '0;
            txn_cnt_q <= '0;
        end else if (bus.clear_stats) begin
            err_sum_q <= '0;
            txn_cnt_q <= '0;
        end else if (out_hs) begin
            err_sum_q <= sum_ext[SUMW] ? '1 : sum_ext[SUMW-1:0];
            if (txn_cnt_q != 16'hFFFF) begin
                txn_cnt_q <= txn_cnt_q + 16'd1;
            end
        end
    end

    assign bus.err_abs = err_abs_c;
    assign bus.err_sum = err_sum_q;
    assign bus.txn_cnt = txn_cnt_q;
`endif
endmodule
